axi4_slave_mem: RTL and testbench
=================================

# axi4_slave_mem

AXI4 slave memory model that consumes the write and read channels driven by the NoC arbiter's `axi4_master_if` agents. It accepts single- and multi-beat bursts on independent write and read FSMs and stores data in an internal word-addressed RAM. Each write burst returns one B response and each read beat returns one R response. It sits directly downstream of the master interface in the uvme top and serves as the target the master sequences write to and read back from.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of 2.
- `ADDR_W`, 32: address width.
- `ACLK` in 1: clock; all logic on rising edge.
- `ARESETn` in 1: synchronous, active-low reset.
- `AWVALID` in 1 / `AWREADY` out 1: write-address handshake.
- `AWADDR` in 32, `AWLEN` in 4, `AWBURST` in 2, `AWSIZE` in 3: write burst attributes.
- `WVALID` in 1 / `WREADY` out 1: write-data handshake.
- `WDATA` in 32, `WSTRB` in 4, `WLAST` in 1: write beat.
- `BVALID` out 1 / `BREADY` in 1, `BRESP` out 2: write response.
- `ARVALID` in 1 / `ARREADY` out 1: read-address handshake.
- `ARADDR` in 32, `ARLEN` in 4, `ARBURST` in 2, `ARSIZE` in 3: read burst attributes.
- `RVALID` out 1 / `RREADY` in 1, `RDATA` out 32, `RRESP` out 2, `RLAST` out 1: read data.

## Operation
- **Write FSM states:** W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: `AWREADY`=1. On AW handshake, latch addr/len/burst/size, clear beat counter and error flag, go to W_DATA.
  - W_DATA: `WREADY`=1. On each W handshake, write the bytes enabled by `WSTRB` to word `addr[log2(DEPTH)+1:2]`, then advance the address.
  - After beat number `len+1`, go to W_RESP. The burst always ends on the beat count, regardless of `WLAST`.
  - W_RESP: `BVALID`=1 with `BRESP` held until `BREADY`, then go to W_IDLE.
- **Read FSM states:** R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: `ARREADY`=1. On AR handshake, latch attributes and issue the beat-0 RAM read.
  - R_DATA: `RVALID`=1. On each R handshake, advance the address and counter.
  - `RLAST`=1 on beat `len`. The handshake on that beat returns the FSM to R_IDLE.
- **Address generation (size fixed at 4 bytes per beat):**
  - FIXED (00): address constant.
  - INCR (01): address +4 per beat.
  - WRAP (10): address +4, wrapping within a boundary of `(len+1)*4` bytes aligned down. `len` must be 1, 3, 7 or 15; any other value is an error.
- **Error rules (OKAY=00, SLVERR=10, DECERR=11):**
  - Write burst with `AWBURST`=11, `AWSIZE`≠2, a bad WRAP length, or a `WLAST` value that disagrees with the beat position: all beats are accepted but discarded, and `BRESP`=SLVERR.
  - Beat whose word index is ≥ `DEPTH`: write is discarded. `BRESP`=DECERR unless SLVERR was already flagged (SLVERR takes priority).
  - Reads: the same checks apply per beat. An errored beat returns `RDATA`=0 with `RRESP`=SLVERR or DECERR.
- The write and read FSMs are fully independent and may run concurrently.

## Timing
- **Reset** (`ARESETn`=0 at an edge): both FSMs go to IDLE.
  - Output values: `AWREADY`=1, `ARREADY`=1; `WREADY`, `BVALID`, `RVALID`, `RLAST`=0; `BRESP`, `RRESP`=00; `RDATA`=0.
  - RAM contents are not cleared.
  - Reset mid-burst abandons the burst: no B or R response is issued for it.
- **Write timing:** AW handshake at edge N → `WREADY`=1 from cycle N+1. One beat can be accepted per cycle.
- **Write response:** last beat accepted at edge M → `BVALID`=1 from cycle M+1.
- **Read timing:** AR handshake at edge N → `RVALID`=1 with beat 0 from cycle N+1.
  - Each subsequent beat is presented the cycle after the previous R handshake.
  - Maximum throughput is 1 beat per cycle.
- **Stability under backpressure:**
  - While `RVALID` && !`RREADY`: `RDATA`, `RRESP` and `RLAST` are held stable.
  - While `BVALID` && !`BREADY`: `BRESP` is held stable.
- **Same-cycle write and read to the same word:** the read returns the old data (read-before-write). The new data is visible to any read issued on a later cycle.
- `AWREADY` is low outside W_IDLE, and `ARREADY` is low outside R_IDLE. Only one outstanding transaction is allowed per direction.
- `WVALID` asserted before the AW handshake is not accepted (`WREADY`=0).

## Test plan
- **Single write then read:** write `AWADDR`=0x10, `AWLEN`=0, INCR, `WDATA`=0xDEADBEEF, `WSTRB`=F → `BRESP`=00 one cycle after the W beat. Then read `ARADDR`=0x10 → `RDATA`=0xDEADBEEF, `RLAST`=1, `RRESP`=00.
- **INCR burst with backpressure:** write 4 beats (0x1..0x4) at 0x40. Read back 4 beats with `RREADY` toggling 1,0,1,0 → data 1,2,3,4 in order, each held while stalled, `RLAST` only on the 4th beat.
- **WRAP and byte strobes:**
  - WRAP burst with `AWLEN`=3 at 0x38 → words written at 0x38, 0x3C, 0x30, 0x34.
  - Then a single write of 0xAABBCCDD with `WSTRB`=0101 to 0x30 → reads back 0xXXBBXXDD, with the upper bytes unchanged.
- **Error paths:**
  - `AWBURST`=11 → `BRESP`=10 and no RAM change.
  - `ARADDR`=DEPTH*4 → `RRESP`=11, `RDATA`=0.
  - `WLAST` asserted early on beat 1 of a 4-beat burst → 4 beats are still accepted, `BRESP`=10.
- **Concurrency:** a write to 0x80 and a read of 0x80 hand shake on the same edge → the read returns the old value. A following read returns the new value.
- **Reset mid-burst:** `ARESETn`=0 at beat 2 of an 8-beat read → next cycle `RVALID`=0, `ARREADY`=1, and no further R beats appear. A new burst then completes normally.

Source files
------------

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent write and read burst FSMs over a word-addressed RAM.
// Supports FIXED/INCR/WRAP bursts of 4-byte beats with SLVERR/DECERR reporting.
module axi4_slave_mem #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [1:0]        AWBURST,
    input  logic [2:0]        AWSIZE,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [1:0]        ARBURST,
    input  logic [2:0]        ARSIZE,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // Next beat address; the wrap mask (len+1)*4-1 equals {len, 2'b11}.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] burst,
                                                    input logic [3:0] len);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'({len, 2'b11});
        unique case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + ADDR_W'(4)) & mask);
            default: return a + ADDR_W'(4);
        endcase
    endfunction

    // Burst attributes that make every beat a SLVERR.
    function automatic logic attr_bad(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [3:0] len);
        return (burst == 2'b11) || (size != 3'd2) ||
               ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return |a[ADDR_W-1:IdxW+2];
    endfunction

    logic [31:0] mem [DEPTH];

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [3:0]        wlen_q, wlen_d, rlen_q, rlen_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0]        wburst_q, wburst_d, rburst_q, rburst_d;
    logic              wslv_q, wslv_d, wdec_q, wdec_d, rbad_q, rbad_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              aw_hs, w_hs, ar_hs, r_hs, w_last, r_last, mem_we;
    logic              beat_slv, load, lbad;
    logic [ADDR_W-1:0] laddr;

    assign aw_hs  = (w_state_q == WIdle) && AWVALID;
    assign w_hs   = (w_state_q == WData) && WVALID;
    assign ar_hs  = (r_state_q == RIdle) && ARVALID;
    assign r_hs   = (r_state_q == RData) && RREADY;
    assign w_last = (wcnt_q == wlen_q);
    assign r_last = (rcnt_q == rlen_q);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            waddr_q   <= '0;
            raddr_q   <= '0;
            wlen_q    <= '0;
            rlen_q    <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            wburst_q  <= '0;
            rburst_q  <= '0;
            wslv_q    <= 1'b0;
            wdec_q    <= 1'b0;
            rbad_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            wlen_q    <= wlen_d;
            rlen_q    <= rlen_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            wburst_q  <= wburst_d;
            rburst_q  <= rburst_d;
            wslv_q    <= wslv_d;
            wdec_q    <= wdec_d;
            rbad_q    <= rbad_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Byte-enabled RAM write; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (WSTRB[b]) mem[waddr_q[IdxW+1:2]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // Next-state logic for both FSMs.
    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        unique case (w_state_q)
            WIdle:   if (aw_hs) w_state_d = WData;
            WData:   if (w_hs && w_last) w_state_d = WResp;
            WResp:   if (BREADY) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
        unique case (r_state_q)
            RIdle:   if (ar_hs) r_state_d = RData;
            RData:   if (r_hs && r_last) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    // Write datapath: latch attributes, accumulate sticky error flags, advance address.
    always_comb begin
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wburst_d = wburst_q;
        wcnt_d   = wcnt_q;
        wslv_d   = wslv_q;
        wdec_d   = wdec_q;
        mem_we   = 1'b0;
        beat_slv = wslv_q || (WLAST != w_last);
        if (aw_hs) begin
            waddr_d  = AWADDR;
            wlen_d   = AWLEN;
            wburst_d = AWBURST;
            wcnt_d   = '0;
            wslv_d   = attr_bad(AWBURST, AWSIZE, AWLEN);
            wdec_d   = 1'b0;
        end else if (w_hs) begin
            wslv_d  = beat_slv;
            wdec_d  = wdec_q || out_of_range(waddr_q);
            // A beat coinciding with reset belongs to an abandoned burst.
            mem_we  = ARESETn && !beat_slv && !out_of_range(waddr_q);
            waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
            wcnt_d  = wcnt_q + 4'd1;
        end
    end

    // Read datapath: each RAM lookup is registered at the edge that issues the beat,
    // so a same-edge write is not visible (read-before-write).
    always_comb begin
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rburst_d = rburst_q;
        rcnt_d   = rcnt_q;
        rbad_d   = rbad_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        load     = 1'b0;
        laddr    = raddr_q;
        lbad     = rbad_q;
        if (ar_hs) begin
            raddr_d  = ARADDR;
            rlen_d   = ARLEN;
            rburst_d = ARBURST;
            rcnt_d   = '0;
            rbad_d   = attr_bad(ARBURST, ARSIZE, ARLEN);
            load     = 1'b1;
            laddr    = ARADDR;
            lbad     = rbad_d;
        end else if (r_hs && !r_last) begin
            raddr_d = next_addr(raddr_q, rburst_q, rlen_q);
            rcnt_d  = rcnt_q + 4'd1;
            load    = 1'b1;
            laddr   = raddr_d;
        end
        if (load) begin
            if (lbad) begin
                rresp_d = 2'b10;
                rdata_d = '0;
            end else if (out_of_range(laddr)) begin
                rresp_d = 2'b11;
                rdata_d = '0;
            end else begin
                rresp_d = 2'b00;
                rdata_d = mem[laddr[IdxW+1:2]];
            end
        end
    end

    // Channel outputs decoded from FSM state; SLVERR outranks DECERR.
    always_comb begin
        AWREADY = (w_state_q == WIdle);
        WREADY  = (w_state_q == WData);
        BVALID  = (w_state_q == WResp);
        BRESP   = 2'b00;
        if (w_state_q == WResp) BRESP = wslv_q ? 2'b10 : (wdec_q ? 2'b11 : 2'b00);
        ARREADY = (r_state_q == RIdle);
        RVALID  = (r_state_q == RData);
        RLAST   = (r_state_q == RData) && r_last;
        RDATA   = rdata_q;
        RRESP   = rresp_q;
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Bench for axi4_slave_mem: spec-level memory model plus R/B expectation queues,
// checked every cycle by one compare process, with literal spot checks.
module tb_axi4_slave_mem;
    localparam int unsigned DEPTH = 256;

    logic        ACLK, ARESETn;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;

    axi4_slave_mem #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWBURST(AWBURST), .AWSIZE(AWSIZE),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARBURST(ARBURST), .ARSIZE(ARSIZE),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    logic [31:0] mdl [DEPTH];
    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    int          nvec = 0;
    int          nfail = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp, last_bresp;
    logic        last_rlast;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic bit attr_err(input logic [1:0] b, input logic [2:0] s,
                                    input logic [3:0] len);
        return (b == 2'b11) || (s != 3'd2) ||
               (b == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Address of beat i, from the burst definitions directly.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b,
                                              input logic [3:0] len, input int i);
        logic [31:0] bytes, base;
        bytes = (32'(len) + 32'd1) * 32'd4;
        case (b)
            2'b00:   return a;
            2'b10: begin
                base = a - (a % bytes);
                return base + ((a - base + 32'(4 * i)) % bytes);
            end
            default: return a + 32'(4 * i);
        endcase
    endfunction

    task automatic push_rd(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        rbeat_t      e;
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, len, i);
            e.last = (i == int'(len));
            if (attr_err(burst, size, len)) begin
                e.data = '0; e.resp = 2'b10;
            end else if (32'(a[31:2]) >= DEPTH) begin
                e.data = '0; e.resp = 2'b11;
            end else begin
                e.data = mdl[a[31:2]]; e.resp = 2'b00;
            end
            rq.push_back(e);
        end
    endtask

    // Single compare process: R and B channels checked whenever valid, including stalls.
    always @(negedge ACLK) begin
        if (RVALID) begin
            if (rq.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL r_unexpected: got beat %h, expected none", RDATA);
            end else begin
                chk("rdata", RDATA, rq[0].data);
                chk("rresp", 32'(RRESP), 32'(rq[0].resp));
                chk("rlast", 32'(RLAST), 32'(rq[0].last));
                if (RREADY) begin
                    last_rdata = RDATA; last_rresp = RRESP; last_rlast = RLAST;
                    void'(rq.pop_front());
                end
            end
        end
        if (BVALID) begin
            if (bq.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL b_unexpected: got bresp %h, expected none", BRESP);
            end else begin
                chk("bresp", 32'(BRESP), 32'(bq[0]));
                if (BREADY) begin
                    last_bresp = BRESP;
                    void'(bq.pop_front());
                end
            end
        end
    end

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [2:0] size,
                               input logic [31:0] d0, input logic [3:0] strb,
                               input int early, input int bstall);
        logic        slv, dec;
        logic [31:0] a, d;
        int          n;
        slv = attr_err(burst, size, len) || (early >= 0 && early != int'(len));
        dec = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, len, i);
            d = d0 + 32'(i);
            if (32'(a[31:2]) >= DEPTH) dec = 1'b1;
            else if (!slv)
                for (int b = 0; b < 4; b++) if (strb[b]) mdl[a[31:2]][b*8 +: 8] = d[b*8 +: 8];
        end
        bq.push_back(slv ? 2'b10 : (dec ? 2'b11 : 2'b00));
        AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size; AWVALID = 1'b1;
        WVALID = 1'b1; WDATA = d0; WSTRB = strb;
        WLAST = (early >= 0) ? (early == 0) : (len == 0);
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 100) begin n++; @(negedge ACLK); end
        chk("awready", 32'(AWREADY), 32'd1);
        chk("wready_before_aw", 32'(WREADY), 32'd0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = d0 + 32'(i);
            WLAST = (early >= 0) ? (i == early) : (i == int'(len));
            @(negedge ACLK);
            chk("wready", 32'(WREADY), 32'd1);
            if (i == 0) chk("awready_busy", 32'(AWREADY), 32'd0);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        @(negedge ACLK);
        chk("bvalid_latency", 32'(BVALID), 32'd1);
        repeat (bstall) begin @(posedge ACLK); #1; end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic read_issue(input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input logic [2:0] size);
        int n;
        ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = size; ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < 100) begin n++; @(negedge ACLK); end
        chk("arready", 32'(ARREADY), 32'd1);
        push_rd(addr, len, burst, size);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    // RREADY follows pat[cycle % 4] until every expected beat has been consumed.
    task automatic read_drain(input logic [3:0] pat);
        int c;
        c = 0;
        RREADY = pat[0];
        @(negedge ACLK);
        chk("rvalid_latency", 32'(RVALID), 32'd1);
        forever begin
            @(posedge ACLK); #1;
            if (rq.size() == 0) break;
            c++;
            if (c > 200) begin
                nvec++; nfail++;
                $display("FAIL r_timeout: got %0d beats pending, expected 0", rq.size());
                rq.delete();
                break;
            end
            RREADY = pat[c % 4];
        end
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        ARESETn = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0;
        RREADY = 1'b0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWSIZE = 3'd2; WDATA = '0;
        WSTRB = '0; WLAST = 1'b0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARSIZE = 3'd2;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", 32'(AWREADY), 32'd1);
        chk("rst_arready", 32'(ARREADY), 32'd1);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_bresp", 32'(BRESP), 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        // Single write then read
        write_burst(32'h10, 4'd0, 2'b01, 3'd2, 32'hDEADBEEF, 4'hF, -1, 0);
        chk("single_bresp", 32'(last_bresp), 32'd0);
        read_issue(32'h10, 4'd0, 2'b01, 3'd2);
        read_drain(4'b1111);
        chk("single_rdata", last_rdata, 32'hDEADBEEF);
        chk("single_rresp", 32'(last_rresp), 32'd0);
        chk("single_rlast", 32'(last_rlast), 32'd1);

        // INCR burst, B stall, R backpressure
        write_burst(32'h40, 4'd3, 2'b01, 3'd2, 32'h1, 4'hF, -1, 2);
        read_issue(32'h40, 4'd3, 2'b01, 3'd2);
        read_drain(4'b0101);
        chk("incr_last_rdata", last_rdata, 32'h4);

        // WRAP and byte strobes
        write_burst(32'h38, 4'd3, 2'b10, 3'd2, 32'h11111111, 4'hF, -1, 0);
        read_issue(32'h30, 4'd3, 2'b01, 3'd2);
        read_drain(4'b1111);
        chk("wrap_word_3c", last_rdata, 32'h11111112);
        write_burst(32'h30, 4'd0, 2'b01, 3'd2, 32'hAABBCCDD, 4'b0101, -1, 0);
        read_issue(32'h30, 4'd0, 2'b01, 3'd2);
        read_drain(4'b1111);
        chk("strobe_word_30", last_rdata, 32'h11BB11DD);

        // Error paths
        write_burst(32'h10, 4'd0, 2'b11, 3'd2, 32'h12345678, 4'hF, -1, 0);
        chk("burst11_bresp", 32'(last_bresp), 32'd2);
        read_issue(32'h10, 4'd0, 2'b01, 3'd2);
        read_drain(4'b1111);
        chk("burst11_unchanged", last_rdata, 32'hDEADBEEF);
        read_issue(32'(DEPTH * 4), 4'd0, 2'b01, 3'd2);
        read_drain(4'b1111);
        chk("oor_rresp", 32'(last_rresp), 32'd3);
        chk("oor_rdata", last_rdata, 32'd0);
        write_burst(32'h200, 4'd3, 2'b01, 3'd2, 32'h5, 4'hF, 1, 0);
        chk("early_wlast_bresp", 32'(last_bresp), 32'd2);

        // Concurrent write beat and read address on the same edge
        write_burst(32'h80, 4'd0, 2'b01, 3'd2, 32'h0BADF00D, 4'hF, -1, 0);
        AWADDR = 32'h80; AWLEN = 4'd0; AWBURST = 2'b01; AWSIZE = 3'd2; AWVALID = 1'b1;
        @(negedge ACLK);
        chk("conc_awready", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1'b1;
        ARADDR = 32'h80; ARLEN = 4'd0; ARBURST = 2'b01; ARSIZE = 3'd2; ARVALID = 1'b1;
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("conc_wready", 32'(WREADY), 32'd1);
        chk("conc_arready", 32'(ARREADY), 32'd1);
        push_rd(32'h80, 4'd0, 2'b01, 3'd2);
        mdl[32] = 32'hCAFEF00D;
        bq.push_back(2'b00);
        @(posedge ACLK); #1;
        WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0; BREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0; BREADY = 1'b0;
        chk("conc_old_data", last_rdata, 32'h0BADF00D);
        read_issue(32'h80, 4'd0, 2'b01, 3'd2);
        read_drain(4'b1111);
        chk("conc_new_data", last_rdata, 32'hCAFEF00D);

        // Reset in the middle of an 8-beat read
        write_burst(32'hC0, 4'd7, 2'b01, 3'd2, 32'hA0, 4'hF, -1, 0);
        read_issue(32'hC0, 4'd7, 2'b01, 3'd2);
        RREADY = 1'b1;
        @(posedge ACLK);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        rq.delete();
        @(negedge ACLK);
        chk("rst_mid_rvalid", 32'(RVALID), 32'd0);
        chk("rst_mid_arready", 32'(ARREADY), 32'd1);
        repeat (3) begin
            @(negedge ACLK);
            chk("rst_mid_no_beats", 32'(RVALID), 32'd0);
        end
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        read_issue(32'hC0, 4'd3, 2'b01, 3'd2);
        read_drain(4'b1111);
        chk("post_rst_rdata", last_rdata, 32'hA3);
        chk("post_rst_rlast", 32'(last_rlast), 32'd1);

        repeat (3) @(posedge ACLK);
        chk("r_leftover", 32'(rq.size()), 32'd0);
        chk("b_leftover", 32'(bq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
